// File: rtl/writeback_mux.sv
`default_nettype none
// ============================================================================
// Module      : writeback_mux
// Description : Writeback source select with write-enable gating, a one-entry
//               registered bypass record of the last committed write, and a
//               committed-write counter.
// Revision    : 1.0 - initial release
// ============================================================================
module writeback_mux #(
  parameter int DATA_WIDTH = 32,
  parameter bit HAS_CSR    = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic [DATA_WIDTH-1:0] load_rdata,
  input  logic [DATA_WIDTH-1:0] pc_plus4,
  input  logic [DATA_WIDTH-1:0] csr_rdata,
  input  logic [1:0]            wb_sel,
  input  logic                  regwrite_in,
  input  logic                  kill_wb,
  input  logic [4:0]            rd_in,
  output logic [DATA_WIDTH-1:0] rd_wdata,
  output logic                  regwrite_out,
  output logic [4:0]            rd_out,
  output logic                  fwd_valid,
  output logic [4:0]            fwd_rd,
  output logic [DATA_WIDTH-1:0] fwd_wdata,
  output logic [31:0]           wb_count
);

  logic [DATA_WIDTH-1:0] w_csr_src;
  logic                  fwd_valid_q, fwd_valid_d;
  logic [4:0]            fwd_rd_q, fwd_rd_d;
  logic [DATA_WIDTH-1:0] fwd_wdata_q, fwd_wdata_d;
  logic [31:0]           wb_count_q, wb_count_d;

  // CSR source is either passed through or tied to zero when CSRs are absent.
  generate
    if (HAS_CSR) begin : g_csr
      assign w_csr_src = csr_rdata;
    end else begin : g_no_csr
      assign w_csr_src = '0;
    end
  endgenerate

  // Ternary tree so an unknown select propagates as X rather than being
  // silently mapped onto one of the sources.
  assign rd_wdata = wb_sel[1] ? (wb_sel[0] ? w_csr_src  : pc_plus4)
                              : (wb_sel[0] ? load_rdata : alu_result);

  // x0 is hardwired to zero, so writes to it never commit.
  assign regwrite_out = regwrite_in & ~kill_wb & (rd_in != 5'd0);
  assign rd_out       = rd_in;

  // Next-state for the bypass record and the commit counter.
  always_comb begin
    fwd_valid_d = regwrite_out;
    fwd_rd_d    = fwd_rd_q;
    fwd_wdata_d = fwd_wdata_q;
    wb_count_d  = wb_count_q;
    if (regwrite_out) begin
      fwd_rd_d    = rd_in;
      fwd_wdata_d = rd_wdata;
      wb_count_d  = wb_count_q + 32'd1;
    end
  end

  // Bypass record and counter registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_valid_q <= 1'b0;
      fwd_rd_q    <= 5'd0;
      fwd_wdata_q <= '0;
      wb_count_q  <= 32'd0;
    end else begin
      fwd_valid_q <= fwd_valid_d;
      fwd_rd_q    <= fwd_rd_d;
      fwd_wdata_q <= fwd_wdata_d;
      wb_count_q  <= wb_count_d;
    end
  end

  assign fwd_valid = fwd_valid_q;
  assign fwd_rd    = fwd_rd_q;
  assign fwd_wdata = fwd_wdata_q;
  assign wb_count  = wb_count_q;

endmodule
`default_nettype wire

// File: tb/tb_writeback_mux.sv
`default_nettype none
// ============================================================================
// Module      : tb_writeback_mux
// Description : Self-checking bench for writeback_mux (HAS_CSR=1 and 0).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_writeback_mux;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] alu_result, load_rdata, pc_plus4, csr_rdata;
  logic [1:0]  wb_sel;
  logic        regwrite_in, kill_wb;
  logic [4:0]  rd_in;

  logic [31:0] rd_wdata, fwd_wdata, wb_count;
  logic        regwrite_out, fwd_valid;
  logic [4:0]  rd_out, fwd_rd;

  logic [31:0] rd_wdata2, fwd_wdata2, wb_count2;
  logic        regwrite_out2, fwd_valid2;
  logic [4:0]  rd_out2, fwd_rd2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  writeback_mux #(.DATA_WIDTH(32), .HAS_CSR(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_result(alu_result), .load_rdata(load_rdata),
    .pc_plus4(pc_plus4), .csr_rdata(csr_rdata),
    .wb_sel(wb_sel), .regwrite_in(regwrite_in), .kill_wb(kill_wb),
    .rd_in(rd_in), .rd_wdata(rd_wdata), .regwrite_out(regwrite_out),
    .rd_out(rd_out), .fwd_valid(fwd_valid), .fwd_rd(fwd_rd),
    .fwd_wdata(fwd_wdata), .wb_count(wb_count)
  );

  writeback_mux #(.DATA_WIDTH(32), .HAS_CSR(1'b0)) dut_nocsr (
    .clk(clk), .rst_n(rst_n),
    .alu_result(alu_result), .load_rdata(load_rdata),
    .pc_plus4(pc_plus4), .csr_rdata(csr_rdata),
    .wb_sel(wb_sel), .regwrite_in(regwrite_in), .kill_wb(kill_wb),
    .rd_in(rd_in), .rd_wdata(rd_wdata2), .regwrite_out(regwrite_out2),
    .rd_out(rd_out2), .fwd_valid(fwd_valid2), .fwd_rd(fwd_rd2),
    .fwd_wdata(fwd_wdata2), .wb_count(wb_count2)
  );

  typedef struct {
    logic [1:0]  sel;
    logic        we;
    logic        kill;
    logic [4:0]  rd;
    logic [31:0] exp_wdata;
    logic [31:0] exp_wdata_nocsr;
    logic        exp_we;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one writeback at the falling edge, then sample after the rising edge.
  task automatic step(input logic [1:0] sel, input logic we, input logic kill,
                      input logic [4:0] rd, input logic [31:0] alu);
    @(negedge clk);
    wb_sel = sel; regwrite_in = we; kill_wb = kill; rd_in = rd; alu_result = alu;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    alu_result = 32'hA1A1A1A1; load_rdata = 32'hB2B2B2B2;
    pc_plus4   = 32'hC3C3C3C3; csr_rdata  = 32'hD4D4D4D4;
    wb_sel = 2'd0; regwrite_in = 1'b0; kill_wb = 1'b0; rd_in = 5'd0;

    //             sel   we    kill  rd     wdata          wdata(no csr)  we_out
    vecs[0] = '{2'd0, 1'b1, 1'b0, 5'd10, 32'hA1A1A1A1, 32'hA1A1A1A1, 1'b1};
    vecs[1] = '{2'd1, 1'b1, 1'b0, 5'd10, 32'hB2B2B2B2, 32'hB2B2B2B2, 1'b1};
    vecs[2] = '{2'd2, 1'b1, 1'b0, 5'd10, 32'hC3C3C3C3, 32'hC3C3C3C3, 1'b1};
    vecs[3] = '{2'd3, 1'b1, 1'b0, 5'd10, 32'hD4D4D4D4, 32'h00000000, 1'b1};
    vecs[4] = '{2'd0, 1'b1, 1'b1, 5'd10, 32'hA1A1A1A1, 32'hA1A1A1A1, 1'b0};
    vecs[5] = '{2'd1, 1'b1, 1'b0, 5'd0,  32'hB2B2B2B2, 32'hB2B2B2B2, 1'b0};
    vecs[6] = '{2'd2, 1'b1, 1'b0, 5'd31, 32'hC3C3C3C3, 32'hC3C3C3C3, 1'b1};
    vecs[7] = '{2'd3, 1'b0, 1'b0, 5'd7,  32'hD4D4D4D4, 32'h00000000, 1'b0};
    vecs[8] = '{2'd0, 1'b1, 1'b1, 5'd0,  32'hA1A1A1A1, 32'hA1A1A1A1, 1'b0};
    vecs[9] = '{2'd1, 1'b1, 1'b0, 5'd1,  32'hB2B2B2B2, 32'hB2B2B2B2, 1'b1};

    #3;
    check("reset fwd_valid", {31'd0, fwd_valid}, 32'd0);
    check("reset fwd_rd",    {27'd0, fwd_rd},    32'd0);
    check("reset fwd_wdata", fwd_wdata,          32'd0);
    check("reset wb_count",  wb_count,           32'd0);

    // Combinational paths work regardless of reset state.
    for (int i = 0; i < 10; i++) begin
      wb_sel = vecs[i].sel; regwrite_in = vecs[i].we;
      kill_wb = vecs[i].kill; rd_in = vecs[i].rd;
      #1;
      check($sformatf("vec%0d rd_wdata", i), rd_wdata, vecs[i].exp_wdata);
      check($sformatf("vec%0d rd_wdata nocsr", i), rd_wdata2, vecs[i].exp_wdata_nocsr);
      check($sformatf("vec%0d regwrite_out", i), {31'd0, regwrite_out}, {31'd0, vecs[i].exp_we});
      check($sformatf("vec%0d rd_out", i), {27'd0, rd_out}, {27'd0, vecs[i].rd});
      check($sformatf("vec%0d rd_out nocsr", i), {27'd0, rd_out2}, {27'd0, vecs[i].rd});
    end

    @(negedge clk);
    regwrite_in = 1'b0;
    rst_n = 1'b1;

    // Bypass capture then a killed write.
    step(2'd0, 1'b1, 1'b0, 5'd5, 32'h12345678);
    check("byp fwd_valid", {31'd0, fwd_valid}, 32'd1);
    check("byp fwd_rd",    {27'd0, fwd_rd},    32'd5);
    check("byp fwd_wdata", fwd_wdata,          32'h12345678);
    check("byp wb_count",  wb_count,           32'd1);
    step(2'd0, 1'b1, 1'b1, 5'd9, 32'h0BADF00D);
    check("kill fwd_valid", {31'd0, fwd_valid}, 32'd0);
    check("kill fwd_rd",    {27'd0, fwd_rd},    32'd5);
    check("kill fwd_wdata", fwd_wdata,          32'h12345678);
    check("kill wb_count",  wb_count,           32'd1);

    // Mid-cycle asynchronous reset clears registered state immediately.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async rst wb_count",  wb_count,           32'd0);
    check("async rst fwd_valid", {31'd0, fwd_valid}, 32'd0);
    check("async rst fwd_rd",    {27'd0, fwd_rd},    32'd0);
    rst_n = 1'b1;

    // Counter: three valid writes, one killed, one to x0, one killed to x0.
    step(2'd1, 1'b1, 1'b0, 5'd3,  32'h1);
    step(2'd2, 1'b1, 1'b0, 5'd4,  32'h2);
    check("pc4 fwd_wdata", fwd_wdata, 32'hC3C3C3C3);
    step(2'd3, 1'b1, 1'b0, 5'd6,  32'h3);
    check("csr fwd_wdata", fwd_wdata, 32'hD4D4D4D4);
    check("csr fwd_wdata nocsr", fwd_wdata2, 32'h00000000);
    step(2'd0, 1'b1, 1'b1, 5'd7,  32'h4);
    step(2'd0, 1'b1, 1'b0, 5'd0,  32'h5);
    check("x0 fwd_valid", {31'd0, fwd_valid}, 32'd0);
    check("x0 fwd_rd",    {27'd0, fwd_rd},    32'd6);
    step(2'd0, 1'b1, 1'b1, 5'd0,  32'h6);
    check("count3 wb_count",       wb_count,  32'd3);
    check("count3 wb_count nocsr", wb_count2, 32'd3);
    check("kill+x0 fwd_valid", {31'd0, fwd_valid}, 32'd0);

    // Counter wrap from the all-ones value.
    @(negedge clk);
    regwrite_in = 1'b0;
    force dut.wb_count_q = 32'hFFFFFFFF;
    #1;
    release dut.wb_count_q;
    #1;
    check("preset wb_count", wb_count, 32'hFFFFFFFF);
    step(2'd0, 1'b1, 1'b0, 5'd12, 32'hCAFE0001);
    check("wrap wb_count",  wb_count,           32'd0);
    check("wrap fwd_valid", {31'd0, fwd_valid}, 32'd1);
    check("wrap fwd_rd",    {27'd0, fwd_rd},    32'd12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
